// File: rtl/alu_exec.sv
// alu_exec: ALU execute stage with single-cycle ops and registered flags.
// Define ALU_EXEC_MUL_EN to build opcode 8 as a 4-step shift-add multiply.
module alu_exec #(
    parameter int WIDTH = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [3:0]         M,
    output logic [2*WIDTH-1:0] Result,
    output logic               Carry,
    output logic               Zero,
    output logic               Ovf,
    output logic               Err,
    output logic               Busy,
    output logic               Done
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_CMP = 4'd9;

    logic [2*WIDTH-1:0] res_q;
    logic               carry_q;
    logic               zero_q;
    logic               ovf_q;
    logic               err_q;
    logic               done_q;

    logic [WIDTH:0]     add_w;
    logic [WIDTH:0]     sub_w;
    logic               add_ovf;
    logic               sub_ovf;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_z;
    logic               alu_v;
    logic               alu_e;

    assign add_w   = {1'b0, A} + {1'b0, B};
    assign sub_w   = {1'b0, A} - {1'b0, B};
    assign add_ovf = (A[WIDTH-1] == B[WIDTH-1]) &&
                     (add_w[WIDTH-1] != A[WIDTH-1]);
    assign sub_ovf = (A[WIDTH-1] != B[WIDTH-1]) &&
                     (sub_w[WIDTH-1] != A[WIDTH-1]);

    // Opcode 8 falls to default here; the multiply path intercepts it first.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_e   = 1'b0;
        case (M)
            OP_ADD: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_v   = add_ovf;
            end
            OP_SUB: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = sub_w[WIDTH];
                alu_v   = sub_ovf;
            end
            OP_AND: alu_res = A & B;
            OP_OR:  alu_res = A | B;
            OP_XOR: alu_res = A ^ B;
            OP_NOT: alu_res = ~A;
            OP_SHL: begin
                alu_res = {A[WIDTH-2:0], 1'b0};
                alu_c   = A[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, A[WIDTH-1:1]};
                alu_c   = A[0];
            end
            OP_CMP: begin
                alu_c   = sub_w[WIDTH];
                alu_v   = sub_ovf;
            end
            default: alu_e = 1'b1;
        endcase
    end

    assign alu_z = (M == OP_CMP) ? (A == B) : (alu_res == '0);

`ifdef ALU_EXEC_MUL_EN
    localparam int         CW     = $clog2(WIDTH);
    localparam logic [3:0] OP_MUL = 4'd8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

    state_e             state_q;
    logic               busy_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [CW-1:0]      cnt_q;

    assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign Busy  = busy_q;
`else
    assign Busy  = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
            if (state_q == S_MUL) begin
                acc_q    <= acc_d;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    res_q   <= acc_d;
                    carry_q <= 1'b0;
                    ovf_q   <= 1'b0;
                    zero_q  <= (acc_d == '0);
                    err_q   <= 1'b0;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            end else
`endif
            if (Start) begin
`ifdef ALU_EXEC_MUL_EN
                if (M == OP_MUL) begin
                    mcand_q  <= {{WIDTH{1'b0}}, A};
                    mplier_q <= B;
                    acc_q    <= '0;
                    cnt_q    <= '0;
                    busy_q   <= 1'b1;
                    state_q  <= S_MUL;
                end else
`endif
                begin
                    res_q   <= {{WIDTH{1'b0}}, alu_res};
                    carry_q <= alu_c;
                    zero_q  <= alu_z;
                    ovf_q   <= alu_v;
                    err_q   <= alu_e;
                    done_q  <= 1'b1;
                end
            end
        end
    end

    assign Result = res_q;
    assign Carry  = carry_q;
    assign Zero   = zero_q;
    assign Ovf    = ovf_q;
    assign Err    = err_q;
    assign Done   = done_q;

endmodule

// File: doc/alu_exec.md
# alu_exec

Execution stage of the ALU datapath, directly downstream of the A, B and M operand registers. On a Start pulse it samples the 4-bit operands A and B and the 4-bit opcode M, then executes the operation. Single-cycle logic/arithmetic ops complete in one clock; multiply uses a 4-iteration shift-add sequencer. It returns a registered 8-bit result with flags and a one-cycle Done pulse.

## Interface
- WIDTH, 4: operand width; result is 2*WIDTH. Only 4 is verified.
- Clk  input  1  sole clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high; sampled on Clk rising edge.
- Start  input  1  request; sampled only when Busy=0.
- A  input  4  operand A, from regA q3..q0 (q0 = bit 0).
- B  input  4  operand B, from regB s3..s0.
- M  input  4  opcode, from regM t3..t0.
- Result  output  8  registered result.
- Carry  output  1  ADD carry-out / SUB borrow.
- Zero  output  1  Result == 0.
- Ovf  output  1  signed 4-bit overflow (ADD/SUB only).
- Err  output  1  illegal opcode on last operation.
- Busy  output  1  multiply in progress.
- Done  output  1  one-cycle completion pulse.

## Operation
- Opcodes:
  - 0 ADD: A+B.
  - 1 SUB: A-B.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 NOT A.
  - 6 SHL A by 1, Carry=A[3].
  - 7 SHR A logical by 1, Carry=A[0].
  - 8 MUL: unsigned A*B.
  - 9 CMP: Result=0, flags as SUB.
  - 10-15 illegal.
- Non-MUL results occupy Result[3:0]; Result[7:4]=0.
- MUL result is the full 8-bit product.
- SUB Carry=1 when A<B (borrow).
- Ovf is computed on ADD/SUB/CMP only; it is 0 for all other ops.
- Zero reflects the written Result. For CMP, Zero=1 when A==B.
- Illegal opcode: Result=0, Zero=1, Carry=0, Ovf=0, Err=1, Done pulses. Err clears on the next legal completion.
- FSM states: IDLE, MUL, plus registered Done.
  - IDLE & Start & M!=8: compute and write Result/flags, pulse Done; stay IDLE.
  - IDLE & Start & M==8: latch A and B, clear accumulator, set counter=0, Busy=1, go MUL.
  - MUL: each cycle, if multiplier bit[0]=1, add multiplicand to accumulator. Shift multiplicand left and multiplier right; counter+1.
  - MUL at counter==3: write Result, Carry=0, Ovf=0, Zero, Err=0, pulse Done, Busy=0, go IDLE.
- Start while Busy=1 is ignored; it is not queued.
- A/B/M changes during MUL have no effect.
- Result and flags hold until the next completion.

## Timing
- Reset: Result=0, Carry=0, Zero=0, Ovf=0, Err=0, Busy=0, Done=0, state=IDLE.
- Reset during MUL aborts the operation. No Done is issued and outputs take reset values at that edge.
- Reset has priority over Start in the same cycle.
- Single-cycle op latency: with Start sampled at edge k, Result, flags and Done=1 are visible after edge k. Done drops after edge k+1 unless a new Start is accepted.
- MUL latency: with Start at edge k, Busy=1 after edge k. Result, Done=1 and Busy=0 follow after edge k+4.
- Back-to-back: Start held high in IDLE issues one operation per cycle, and Done stays high continuously.
- Start may be asserted in the same cycle Done is high after a MUL (state already IDLE); it is accepted.

## Configuration
- ALU_EXEC_MUL_EN defined: opcode 8 is a multi-cycle multiply as above; MUL state and shift-add datapath are present.
- ALU_EXEC_MUL_EN undefined: no MUL state or multiplier logic.
  - Opcode 8 is treated as illegal: one-cycle completion with Err=1, Result=0, Zero=1.
  - Busy is tied to 0.

## Test plan
- Reset during MUL: A=15, B=15, M=8, Start; assert Reset after 2 cycles -> Busy=0, Done never pulses, Result=0, all flags 0.
- ADD overflow: A=7, B=1, M=0, Start -> after 1 edge Result=0x08, Carry=0, Ovf=1, Zero=0, Done one cycle.
- SUB borrow and CMP equal:
  - A=3, B=5, M=1 -> Result=0x0E, Carry=1, Ovf=0.
  - A=9, B=9, M=9 -> Result=0, Zero=1, Carry=0.
- MUL (macro defined): A=15, B=15, M=8 -> Busy=1 for 4 cycles; Done with Result=0xE1, Zero=0; a Start pulse mid-operation is ignored.
- Illegal opcode: M=12, Start -> Result=0, Zero=1, Err=1, Done. A following ADD 2+2 -> Result=0x04, Err=0.
- Back-to-back ops: Start held for 3 cycles with AND(0xC,0xA), OR(0xC,0xA), XOR(0xC,0xA) -> Results 0x08, 0x0E, 0x06 on consecutive cycles, Done high for 3 cycles.
